// File: rtl/tx_intf_pkg.sv
// tx_intf_pkg: shared state encoding and constants for the TX I/Q
// read-side scheduler (tx_iq_rd_sched).
package tx_intf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_STREAM,
    ST_TAIL,
    ST_DONE
  } tx_state_e;

  localparam int IQ_PACK_W = 32;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/tx_rate_strobe.sv
// tx_rate_strobe: loadable down-counter giving one strobe per
// (i_div+1) enabled clocks; the first strobe follows a load immediately.
module tx_rate_strobe #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_strobe
);

  logic [DIV_WIDTH-1:0] r_cnt;

  assign o_strobe = i_en && (r_cnt == '0);

  // i_div is only sampled on reload, so a new rate starts cleanly
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (o_strobe) begin
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tx_iq_rd_sched.sv
// tx_iq_rd_sched: TX I/Q FIFO read scheduler (prefill, paced drain, underrun fill).
// Define TX_IQ_TAIL_PAD_EN to append TAIL_LEN zero samples after each packet.
module tx_iq_rd_sched
  import tx_intf_pkg::*;
#(
  parameter int IQ_DATA_WIDTH = IQ_PACK_W / 2,
  parameter int CNT_WIDTH     = 11,
  parameter int DIV_WIDTH     = 8,
  parameter int TAIL_LEN      = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [CNT_WIDTH-1:0]       prefill_thr,
  input  logic [DIV_WIDTH-1:0]       rate_div,
  input  logic                       pkt_end,
  input  logic                       tx_abort,
  input  logic [CNT_WIDTH-1:0]       fifo_count,
  input  logic                       fifo_empty,
  input  logic [2*IQ_DATA_WIDTH-1:0] fifo_dout,
  output logic                       fifo_rden,
  output logic                       fifo_flush,
  input  logic                       dac_ready,
  output logic [2*IQ_DATA_WIDTH-1:0] iq_out,
  output logic                       iq_out_valid,
  output logic                       tx_active,
  output logic                       tx_done,
  output logic [15:0]                underrun_cnt
);

  localparam int PW = 2 * IQ_DATA_WIDTH;

  tx_state_e     r_state;
  logic [PW-1:0] r_iq;
  logic          r_valid;
  logic          r_flush;
  logic          r_active;
  logic          r_done;
  logic          r_seen;
  logic [15:0]   r_urun;
  logic          w_stb;
  logic          w_run;

`ifdef TX_IQ_TAIL_PAD_EN
  localparam int TW = $clog2(TAIL_LEN + 1);
  logic [TW-1:0] r_tail;
`endif

  assign w_run = (r_state == ST_STREAM) || (r_state == ST_TAIL);

  tx_rate_strobe #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_stb (
    .clk      (clk),
    .rstn     (rstn),
    .i_load   (!w_run),
    .i_en     (w_run),
    .i_div    (rate_div),
    .o_strobe (w_stb)
  );

  assign fifo_rden = rstn && !tx_abort && (r_state == ST_STREAM)
                  && w_stb && dac_ready && !fifo_empty;

  assign fifo_flush   = r_flush;
  assign iq_out       = r_iq;
  assign iq_out_valid = r_valid;
  assign tx_active    = r_active;
  assign tx_done      = r_done;
  assign underrun_cnt = r_urun;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_iq     <= '0;
      r_valid  <= 1'b0;
      r_flush  <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_seen   <= 1'b0;
      r_urun   <= '0;
`ifdef TX_IQ_TAIL_PAD_EN
      r_tail   <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_done  <= 1'b0;
      if (tx_abort && (r_state != ST_IDLE)) begin
        r_state  <= ST_IDLE;
        r_flush  <= 1'b1;
        r_iq     <= '0;
        r_active <= 1'b0;
        r_seen   <= 1'b0;
      end else begin
        unique case (r_state)
          // hold off while our own flush is still reaching the FIFO
          ST_IDLE: begin
            if (!fifo_empty && !r_flush) begin
              r_state  <= ST_PREFILL;
              r_active <= 1'b1;
              r_urun   <= '0;
              r_seen   <= pkt_end;
            end
          end
          ST_PREFILL: begin
            if (pkt_end) r_seen <= 1'b1;
            if ((fifo_count >= prefill_thr) || r_seen) begin
              r_state <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            if (pkt_end) r_seen <= 1'b1;
            if (w_stb) begin
              if (fifo_empty && r_seen) begin
`ifdef TX_IQ_TAIL_PAD_EN
                r_state  <= ST_TAIL;
                r_tail   <= '0;
`else
                r_state  <= ST_DONE;
                r_done   <= 1'b1;
                r_active <= 1'b0;
`endif
              end else if (dac_ready) begin
                r_valid <= 1'b1;
                if (!fifo_empty) begin
                  r_iq <= fifo_dout;
                end else begin
                  r_iq <= '0;
                  if (r_urun != UNDERRUN_MAX) r_urun <= r_urun + 16'd1;
                end
              end
            end
          end
          ST_TAIL: begin
`ifdef TX_IQ_TAIL_PAD_EN
            if (r_tail == TW'(TAIL_LEN)) begin
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_active <= 1'b0;
            end else if (w_stb && dac_ready) begin
              r_valid <= 1'b1;
              r_iq    <= '0;
              r_tail  <= r_tail + 1'b1;
            end
`else
            r_state <= ST_IDLE;
`endif
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_seen  <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_iq_rd_sched.sv
// tb_tx_iq_rd_sched: directed + randomized bench with a queue-based FIFO
// and an expected-sample scoreboard for tx_iq_rd_sched.
`timescale 1ns/1ps
module tb_tx_iq_rd_sched;
  import tx_intf_pkg::*;

  localparam int CW = 11;
  localparam int DW = 8;
  localparam int PW = IQ_PACK_W;
`ifdef TX_IQ_TAIL_PAD_EN
  localparam int EXP_TAIL = 16;
`else
  localparam int EXP_TAIL = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [CW-1:0] prefill_thr = '0;
  logic [DW-1:0] rate_div = '0;
  logic          pkt_end = 1'b0;
  logic          tx_abort = 1'b0;
  logic          dac_ready = 1'b0;
  logic [CW-1:0] fifo_count = '0;
  logic          fifo_empty = 1'b1;
  logic [PW-1:0] fifo_dout = '0;
  logic          fifo_rden;
  logic          fifo_flush;
  logic [PW-1:0] iq_out;
  logic          iq_out_valid;
  logic          tx_active;
  logic          tx_done;
  logic [15:0]   underrun_cnt;

  logic          wr = 1'b0;
  logic [PW-1:0] wdata = '0;
  logic [PW-1:0] fq[$];
  logic [PW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc, zeros, tail_zeros, real_n, done_cnt, done_cyc;
  int prev_real, gap_min, gap_max, first_rden, c_thr;
  bit seen_flag;

  always #5 clk = ~clk;

  tx_iq_rd_sched #(
    .IQ_DATA_WIDTH (PW / 2),
    .CNT_WIDTH     (CW),
    .DIV_WIDTH     (DW),
    .TAIL_LEN      (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .prefill_thr  (prefill_thr),
    .rate_div     (rate_div),
    .pkt_end      (pkt_end),
    .tx_abort     (tx_abort),
    .fifo_count   (fifo_count),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rden    (fifo_rden),
    .fifo_flush   (fifo_flush),
    .dac_ready    (dac_ready),
    .iq_out       (iq_out),
    .iq_out_valid (iq_out_valid),
    .tx_active    (tx_active),
    .tx_done      (tx_done),
    .underrun_cnt (underrun_cnt)
  );

  // FWFT FIFO model: status outputs update after the edge
  always @(posedge clk) begin
    if (fifo_flush) fq.delete();
    else if (fifo_rden && fq.size() > 0) void'(fq.pop_front());
    if (wr) fq.push_back(wdata);
    fifo_count <= CW'(fq.size());
    fifo_empty <= (fq.size() == 0);
    fifo_dout  <= (fq.size() > 0) ? fq[0] : '0;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start(input int thr, input int div);
    prefill_thr = CW'(thr);
    rate_div    = DW'(div);
    exp_q.delete();
    zeros = 0; tail_zeros = 0; real_n = 0;
    done_cnt = 0; done_cyc = -1;
    prev_real = -1; gap_min = 1000000; gap_max = 0;
    first_rden = -1; c_thr = -1;
    seen_flag = 1'b0;
  endtask

  task automatic push(input logic [PW-1:0] d);
    wr = 1'b1;
    wdata = d;
    exp_q.push_back(d);
  endtask

  task automatic tick();
    logic [PW-1:0] e;
    @(negedge clk);
    cyc++;
    chk("rden_guard", 64'(fifo_rden & (fifo_empty | ~tx_active)), 64'd0);
    if (iq_out_valid) begin
      if (iq_out == '0) begin
        zeros++;
        if (seen_flag && exp_q.size() == 0) tail_zeros++;
      end else begin
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("data_order", iq_out, e);
        real_n++;
        if (prev_real >= 0) begin
          if (cyc - prev_real < gap_min) gap_min = cyc - prev_real;
          if (cyc - prev_real > gap_max) gap_max = cyc - prev_real;
        end
        prev_real = cyc;
      end
    end
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_inactive", tx_active, 0);
    end
    if (fifo_rden && first_rden < 0) first_rden = cyc;
    if (c_thr < 0 && fifo_count >= prefill_thr) c_thr = cyc;
    if (pkt_end) seen_flag = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget, input int mode);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (mode == 1) dac_ready = ~dac_ready;
      else if (mode == 2) dac_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    dac_ready = 1'b1;
    repeat (3) tick();
    chk({tag, "_one_done"}, done_cnt, 1);
  endtask

  task automatic finish_scn(input string tag, input int n);
    chk({tag, "_samples"}, real_n, n);
    chk({tag, "_underrun"}, underrun_cnt, zeros - tail_zeros);
    chk({tag, "_tail"}, tail_zeros, EXP_TAIL);
  endtask

  initial begin
    int n;
    cyc = 0;
    start(0, 0);
    repeat (3) @(negedge clk);
    chk("rst_iq", iq_out, 0);
    chk("rst_valid", iq_out_valid, 0);
    chk("rst_rden", fifo_rden, 0);
    chk("rst_flush", fifo_flush, 0);
    chk("rst_active", tx_active, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_urun", underrun_cnt, 0);
    rstn = 1'b1;
    dac_ready = 1'b1;
    tick();

    // prefill 64, one sample every 2 clocks
    start(64, 1);
    for (int i = 0; i < 100; i++) begin
      push($urandom | 32'h1);
      tick();
    end
    wr = 1'b0;
    pkt_end = 1'b1; tick(); pkt_end = 1'b0;
    wait_done("s1", 1000, 0);
    finish_scn("s1", 100);
    chk("s1_first_rden", first_rden, c_thr + 1);
    chk("s1_gap_min", gap_min, 2);
    chk("s1_gap_max", gap_max, 2);
`ifndef TX_IQ_TAIL_PAD_EN
    chk("s1_done_lat", done_cyc - prev_real, 2);
`endif

    // starve the stream for five strobes between two bursts
    start(10, 0);
    for (int i = 0; i < 10; i++) begin
      push($urandom | 32'h1);
      tick();
    end
    wr = 1'b0;
    n = 0;
    while (!fifo_empty && n < 100) begin
      tick();
      n++;
    end
    chk("s2_drained", fifo_empty, 1);
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      push($urandom | 32'h1);
      pkt_end = (i == 9);
      tick();
    end
    wr = 1'b0; pkt_end = 1'b0;
    wait_done("s2", 500, 0);
    finish_scn("s2", 20);
    chk("s2_urun5", underrun_cnt, 5);
    chk("s2_zero5", zeros - tail_zeros, 5);

    // short packet below threshold
    start(64, 0);
    for (int i = 0; i < 8; i++) begin
      push($urandom | 32'h1);
      tick();
    end
    wr = 1'b0;
    pkt_end = 1'b1; tick(); pkt_end = 1'b0;
    wait_done("s3", 500, 0);
    finish_scn("s3", 8);
    chk("s3_urun0", underrun_cnt, 0);

    // dac_ready alternating every strobe
    start(32, 0);
    for (int i = 0; i < 32; i++) begin
      dac_ready = ~dac_ready;
      push($urandom | 32'h1);
      tick();
    end
    wr = 1'b0;
    pkt_end = 1'b1; tick(); pkt_end = 1'b0;
    wait_done("s4", 500, 1);
    finish_scn("s4", 32);
    chk("s4_urun0", underrun_cnt, 0);

    // abort mid-stream
    start(4, 0);
    for (int i = 0; i < 20; i++) begin
      push($urandom | 32'h1);
      tick();
    end
    wr = 1'b0;
    repeat (2) tick();
    chk("ab_active_before", tx_active, 1);
    tx_abort = 1'b1; tick(); tx_abort = 1'b0;
    chk("ab_flush", fifo_flush, 1);
    chk("ab_iq", iq_out, 0);
    chk("ab_valid", iq_out_valid, 0);
    chk("ab_active", tx_active, 0);
    exp_q.delete();
    tick();
    chk("ab_flush_pulse", fifo_flush, 0);
    repeat (20) tick();
    chk("ab_no_done", done_cnt, 0);
    chk("ab_idle", tx_active, 0);
    chk("ab_fifo_empty", fifo_empty, 1);

    // randomized packets: rate, threshold, gaps and back-pressure
    for (int r = 0; r < 4; r++) begin
      start($urandom_range(1, 40), $urandom_range(0, 3));
      n = $urandom_range(20, 60);
      for (int i = 0; i < n; i++) begin
        dac_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) < 3) begin
          wr = 1'b0;
          tick();
        end
        push($urandom | 32'h1);
        tick();
      end
      wr = 1'b0;
      pkt_end = 1'b1; tick(); pkt_end = 1'b0;
      wait_done("rnd", 3000, 2);
      finish_scn("rnd", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
